// File: rtl/quad_cmd_pkg.sv
// rtl/quad_cmd_pkg.sv - command encodings, frame type and sequencer states for the quad command link
package quad_cmd_pkg;

    localparam logic [7:0] REQ_BATT  = 8'h01;
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;
    localparam logic [7:0] ACK       = 8'hA5;
    localparam logic [7:0] END_MARK  = 8'h00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_FRM,
        S_WAIT_RSP,
        S_CHECK,
        S_RETRY,
        S_NEXT,
        S_DONE
    } seq_state_t;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [15:0] data;
    } cmd_frame_t;

endpackage

// File: rtl/cmd_frame_tbl.sv
// rtl/cmd_frame_tbl.sv - command frame register file, one write port and two async read ports
module cmd_frame_tbl
    import quad_cmd_pkg::*;
#(
    parameter int NUM_CMDS = 8
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_CMDS)-1:0] wr_idx,
    input  cmd_frame_t                  wr_frame,
    input  logic [$clog2(NUM_CMDS)-1:0] rd0_idx,
    output cmd_frame_t                  rd0_frame,
    input  logic [$clog2(NUM_CMDS)-1:0] rd1_idx,
    output cmd_frame_t                  rd1_frame
);

    cmd_frame_t mem_q [NUM_CMDS];

    // Storage deliberately has no reset; the host reloads it before use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_frame;
        end
    end

    assign rd0_frame = mem_q[rd0_idx];
    assign rd1_frame = mem_q[rd1_idx];

endmodule

// File: rtl/remote_cmd_seq.sv
// rtl/remote_cmd_seq.sv - plays a command table through CommMaster, checks responses, retries on NAK/timeout
module remote_cmd_seq
    import quad_cmd_pkg::*;
#(
    parameter int NUM_CMDS    = 8,
    parameter int TIMEOUT_CYC = 1000000,
    parameter int MAX_RETRY   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_CMDS)-1:0] wr_idx,
    input  logic [7:0]                  wr_cmd,
    input  logic [15:0]                 wr_data,
    input  logic                        go,
    output logic [7:0]                  cmd,
    output logic [15:0]                 data,
    output logic                        snd_cmd,
    input  logic                        frm_snt,
    input  logic                        resp_rdy,
    input  logic [7:0]                  resp,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [$clog2(NUM_CMDS)-1:0] err_idx,
    output logic [7:0]                  batt_lvl,
    output logic                        batt_vld
);

    localparam int IW = $clog2(NUM_CMDS);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TMO_SAT   = '1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CMDS - 1);

    seq_state_t    state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, err_idx_q, err_idx_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [TW-1:0] tmo_q, tmo_d, tmo_inc;
    logic [7:0]    cmd_q, cmd_d, resp_q, resp_d, batt_lvl_q, batt_lvl_d;
    logic [15:0]   data_q, data_d;
    logic          err_q, err_d, batt_vld_q, batt_vld_d, tmo_hit;
    cmd_frame_t    rd0_frame, rd1_frame;

    // idx is held at 0 whenever idle, so read port 0 already points at the first entry on go.
    cmd_frame_tbl #(.NUM_CMDS(NUM_CMDS)) u_tbl (
        .clk       (clk),
        .wr_en     (wr_en && !busy),
        .wr_idx    (wr_idx),
        .wr_frame  ({wr_cmd, wr_data}),
        .rd0_idx   (idx_q),
        .rd0_frame (rd0_frame),
        .rd1_idx   (IW'(idx_q + 1'b1)),
        .rd1_frame (rd1_frame)
    );

    assign tmo_inc = (tmo_q == TMO_SAT) ? tmo_q : tmo_q + 1'b1;
    assign tmo_hit = (tmo_q >= TMO_LAST);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        retry_d    = retry_q;
        tmo_d      = '0;
        cmd_d      = cmd_q;
        data_d     = data_q;
        resp_d     = resp_q;
        err_d      = err_q;
        err_idx_d  = err_idx_q;
        batt_lvl_d = batt_lvl_q;
        batt_vld_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_SEND;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    retry_d = '0;
                    cmd_d   = rd0_frame.cmd;
                    data_d  = rd0_frame.data;
                end
            end
            S_SEND: begin
                tmo_d   = tmo_inc;
                state_d = (cmd_q == END_MARK) ? S_DONE : S_WAIT_FRM;
            end
            S_WAIT_FRM: begin
                tmo_d = tmo_inc;
                if (frm_snt)      state_d = S_WAIT_RSP;
                else if (tmo_hit) state_d = S_RETRY;
            end
            S_WAIT_RSP: begin
                tmo_d = tmo_inc;
                if (resp_rdy) begin
                    resp_d  = resp;
                    state_d = S_CHECK;
                end else if (tmo_hit) begin
                    state_d = S_RETRY;
                end
            end
            S_CHECK: begin
                if (cmd_q == REQ_BATT) begin
                    batt_lvl_d = resp_q;
                    batt_vld_d = 1'b1;
                    state_d    = S_NEXT;
                end else begin
                    state_d = (resp_q == ACK) ? S_NEXT : S_RETRY;
                end
            end
            S_RETRY: begin
                if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 1'b1;
                    state_d = S_SEND;
                end else begin
                    err_d     = 1'b1;
                    err_idx_d = idx_q;
                    idx_d     = '0;
                    retry_d   = '0;
                    state_d   = S_IDLE;
                end
            end
            S_NEXT: begin
                retry_d = '0;
                if (idx_q == IDX_LAST || rd1_frame.cmd == END_MARK) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    cmd_d   = rd1_frame.cmd;
                    data_d  = rd1_frame.data;
                    state_d = S_SEND;
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            retry_q    <= '0;
            tmo_q      <= '0;
            cmd_q      <= '0;
            data_q     <= '0;
            resp_q     <= '0;
            err_q      <= 1'b0;
            err_idx_q  <= '0;
            batt_lvl_q <= '0;
            batt_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            resp_q     <= resp_d;
            err_q      <= err_d;
            err_idx_q  <= err_idx_d;
            batt_lvl_q <= batt_lvl_d;
            batt_vld_q <= batt_vld_d;
        end
    end

    assign cmd      = cmd_q;
    assign data     = data_q;
    assign snd_cmd  = (state_q == S_SEND) && (cmd_q != END_MARK);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign err      = err_q;
    assign err_idx  = err_idx_q;
    assign batt_lvl = batt_lvl_q;
    assign batt_vld = batt_vld_q;

endmodule
